// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared types and constants for the push-button conditioning blocks.
//   hold_state_t : states of the press/hold tracker in key_debounce
//   KEY_PRESSED  : raw/debounced key level while the button is held (active-low)
//   KEY_RELEASED : raw/debounced key level while the button is idle
//   max_u()      : constant helper used to size the shared hold counter
// -----------------------------------------------------------------------------
package key_pkg;

  typedef enum logic [1:0] {
    HOLD_IDLE   = 2'd0,
    HOLD_WAIT   = 2'd1,
    HOLD_REPEAT = 2'd2
  } hold_state_t;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // Larger of two non-negative values; used at elaboration time only.
  function automatic int max_u(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_sync.sv
// -----------------------------------------------------------------------------
// key_sync
// Multi-flop synchroniser for one asynchronous key line. Every stage resets
// to the released level so a reset never looks like a press.
//   Parameters: STAGES - number of flops in the chain (>= 2)
//   clk  in  system clock
//   rstn in  asynchronous active-low reset
//   d    in  raw asynchronous input
//   q    out synchronised output (last stage)
// -----------------------------------------------------------------------------
module key_sync
  import key_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_r <= {STAGES{KEY_RELEASED}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises and debounces one raw active-low push-button and derives
// single-cycle event pulses from the clean level.
//   Parameters:
//     SYNC_STAGES - synchroniser depth (>= 2)
//     DEBOUNCE    - stable cycles needed before level follows the key (>= 1)
//     LONG        - cycles from press pulse to long_press pulse (>= 1)
//     REPEAT      - cycles between repeat pulses after long_press (0 = off)
//   Ports:
//     clk         in  system clock
//     rstn        in  asynchronous active-low reset
//     key         in  raw button, 0 = pressed, asynchronous
//     level       out debounced key, same polarity as key, registered
//     press       out one-cycle pulse when level falls
//     release_evt out one-cycle pulse when level rises
//     long_press  out one-cycle pulse once per hold, LONG cycles after press
//     repeat_evt  out periodic one-cycle pulse while held after long_press
//   The release/repeat events carry an _evt suffix because the bare words are
//   SystemVerilog keywords.
// -----------------------------------------------------------------------------
module key_debounce
  import key_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 1_000_000,
  parameter int LONG        = 50_000_000,
  parameter int REPEAT      = 10_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key,
  output logic level,
  output logic press,
  output logic release_evt,
  output logic long_press,
  output logic repeat_evt
);

  localparam int DB_W   = $clog2(DEBOUNCE + 32'sd1);
  localparam int HOLD_W = $clog2(max_u(LONG, REPEAT) + 32'sd1);

  localparam logic [DB_W-1:0]   DB_ZERO   = {DB_W{1'b0}};
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(32'sd1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 32'sd1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'sd1);
  localparam logic [HOLD_W-1:0] LONG_CNT  = HOLD_W'(LONG);
  localparam logic [HOLD_W-1:0] REP_CNT   = HOLD_W'(REPEAT);
  localparam bit                REPEAT_ON = (REPEAT > 32'sd0);

  logic              sync_s;
  logic              sync_diff_s;
  logic              db_hit_s;
  logic              press_evt_s;
  logic              release_evt_s;

  logic [DB_W-1:0]   db_cnt_r;
  logic              level_r;
  logic              press_r;
  logic              release_r;

  hold_state_t       hold_state_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              parked_r;
  logic              long_r;
  logic              repeat_r;

  key_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (key),
    .q    (sync_s)
  );

  // Decode the debounce threshold and classify the resulting level change.
  // The hold tracker uses the same decode so it moves on the very edge that
  // registers press/release, keeping long_press exactly LONG cycles later.
  always_comb begin
    sync_diff_s   = (sync_s != level_r);
    db_hit_s      = sync_diff_s && (db_cnt_r == DB_LAST);
    press_evt_s   = db_hit_s && (sync_s == KEY_PRESSED);
    release_evt_s = db_hit_s && (sync_s == KEY_RELEASED);
  end

  // Debounce counter, clean level and press/release edge registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_cnt_r  <= DB_ZERO;
      level_r   <= KEY_RELEASED;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      press_r   <= press_evt_s;
      release_r <= release_evt_s;
      if (!sync_diff_s) begin
        // Any cycle that agrees with the current level restarts the count.
        db_cnt_r <= DB_ZERO;
      end else if (db_hit_s) begin
        level_r  <= sync_s;
        db_cnt_r <= DB_ZERO;
      end else begin
        db_cnt_r <= db_cnt_r + DB_ONE;
      end
    end
  end

  // Hold tracker: times long_press from the press edge, then repeat pulses.
  // A release edge always wins over a threshold hit on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_state_r <= HOLD_IDLE;
      hold_cnt_r   <= HOLD_ZERO;
      parked_r     <= 1'b0;
      long_r       <= 1'b0;
      repeat_r     <= 1'b0;
    end else begin
      long_r   <= 1'b0;
      repeat_r <= 1'b0;
      if (release_evt_s) begin
        hold_state_r <= HOLD_IDLE;
        hold_cnt_r   <= HOLD_ZERO;
        parked_r     <= 1'b0;
      end else begin
        case (hold_state_r)
          HOLD_IDLE: begin
            if (press_evt_s) begin
              hold_state_r <= HOLD_WAIT;
              hold_cnt_r   <= HOLD_ONE;
              parked_r     <= 1'b0;
            end else begin
              hold_cnt_r   <= HOLD_ZERO;
            end
          end
          HOLD_WAIT: begin
            if (parked_r) begin
              // long_press already fired and repeat is disabled: stay silent
              // until the key is released.
              hold_cnt_r <= hold_cnt_r;
            end else if (hold_cnt_r == LONG_CNT) begin
              long_r <= 1'b1;
              if (REPEAT_ON) begin
                hold_state_r <= HOLD_REPEAT;
                hold_cnt_r   <= HOLD_ONE;
              end else begin
                parked_r     <= 1'b1;
              end
            end else begin
              hold_cnt_r <= hold_cnt_r + HOLD_ONE;
            end
          end
          HOLD_REPEAT: begin
            if (hold_cnt_r == REP_CNT) begin
              repeat_r   <= 1'b1;
              hold_cnt_r <= HOLD_ONE;
            end else begin
              hold_cnt_r <= hold_cnt_r + HOLD_ONE;
            end
          end
          default: begin
            hold_state_r <= HOLD_IDLE;
            hold_cnt_r   <= HOLD_ZERO;
            parked_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign level       = level_r;
  assign press       = press_r;
  assign release_evt = release_r;
  assign long_press  = long_r;
  assign repeat_evt  = repeat_r;

endmodule
